rca_wb_sequencer: RTL and testbench
===================================

Name: rca_wb_sequencer

Overview:
- RCA-side (slave) end of the CPU/RCA issue and writeback protocol.
- Accepts issued RCA operations from the CPU issue stage and tags each with its issue_id.
- Launches the operation on the RCA grid, collects the grid's multi-port results in order, and presents them to CPU writeback as done/wb_id/rd1..rd5 until the CPU acks.
- Drives ready and rca_config_locked so the CPU can neither over-issue nor reconfigure while operations are in flight.

Parameters:
XLEN, 32, datapath width
NUM_WRITE_PORTS, 5, result ports per operation (rd1..rd5)
MAX_IDS, 8, CPU instruction ID space; ID width = $clog2(MAX_IDS)
DEPTH, 4, max outstanding operations (issued, not yet acked); power of 2, ≥2

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
new_request  in  1  CPU issues an RCA op this cycle (valid only when ready=1)
issue_id  in  $clog2(MAX_IDS)  ID of the issued op
ready  out  1  RCA can accept new_request
grid_start  out  1  one-cycle launch pulse to RCA grid
grid_ready  in  1  grid can accept a launch
grid_done  in  1  grid result valid (in launch order)
grid_results  in  NUM_WRITE_PORTS*XLEN  grid result ports, port 0 in LSBs
done  out  1  writeback result valid
wb_id  out  $clog2(MAX_IDS)  ID of presented result
rd  out  NUM_WRITE_PORTS*XLEN  presented results; rd1 = bits [XLEN-1:0], etc.
ack  in  1  CPU consumed presented result
rca_config_locked  out  1  ops in flight; config writes forbidden
protocol_err  out  1  sticky protocol violation flag

Behaviour:
- Reset (rst=0 at a clk edge): both FIFOs empty, occupancy=0, protocol_err=0.
- Outputs while/after reset: done=0, wb_id=0, rd=0, grid_start=0, rca_config_locked=0; ready = grid_ready.
- Reset mid-operation: all in-flight IDs and results are discarded with no writeback.
- State is held in two in-order FIFOs of DEPTH entries:
  - id FIFO holds IDs issued but not acked.
  - result FIFO holds grid results not yet acked.
  - occupancy counts id FIFO entries, range 0..DEPTH, width $clog2(DEPTH)+1.
- ready = (occupancy < DEPTH) && grid_ready. Combinational; depends on registered state and grid_ready only.
- Issue: an accepted issue is new_request && ready.
  - It pushes issue_id into the id FIFO.
  - grid_start = accepted issue, combinational, same cycle.
  - new_request while ready=0 is ignored and sets protocol_err.
- Grid completion: grid_done pushes grid_results into the result FIFO.
  - If the result FIFO count already equals the count of pending launches, grid_done is ignored and sets protocol_err.
  - Pending launches = id FIFO count; a done with no outstanding launch is an error.
- Writeback presentation:
  - done = result FIFO non-empty.
  - wb_id = id FIFO head; rd = result FIFO head.
  - All three are driven from registered state, giving one-cycle minimum latency from grid_done to done.
  - While done=1 and ack=0, wb_id and rd hold stable.
  - When done=0, wb_id and rd are zero.
- Ack: ack && done pops both FIFOs. ack while done=0 is ignored and sets protocol_err.
- Occupancy update: +1 on accepted issue, −1 on valid ack; both in the same cycle leaves it unchanged.
- Simultaneous push and pop on a FIFO:
  - Allowed at any count, including full, because a pop frees a slot.
  - An issue while occupancy==DEPTH is still blocked, because ready uses the registered occupancy.
- rca_config_locked = (occupancy != 0).
- Pointers wrap modulo DEPTH.
- Throughput: one issue and one ack per cycle sustained.
- grid_done with an empty result FIFO is registered, so done rises the next cycle; there is no combinational bypass.
- protocol_err clears only on reset.

Decomposition:
- rca_config package additions:
  - RCA_WB_DEPTH constant.
  - rca_wb_result_t typedef: packed array [NUM_WRITE_PORTS-1:0] of logic [XLEN-1:0].
  - id_t typedef: logic [$clog2(MAX_IDS)-1:0].
- One sub-module, rca_wb_fifo: parameterised width/depth synchronous FIFO with push, pop, head, count, full, empty. Instantiated twice (ID FIFO and result FIFO).
- Control logic (occupancy, ready, error) lives in the top module.

Test Plan:
1. Reset then single op:
   - Stimulus: issue id=3; grid_done 2 cycles later with rd1=0x11..rd5=0x55.
   - Required: done=1 the cycle after grid_done with wb_id=3, rd1..rd5 correct; locked=1 from issue until ack; after ack, done=0 and locked=0.
2. Back-pressure:
   - Stimulus: issue ids 0,1,2,3 on consecutive cycles with no grid_done.
   - Required: ready=0 once occupancy=4; a 5th new_request is ignored and sets protocol_err=1.
3. In-order drain:
   - Stimulus: 4 ops outstanding, grid_done on 4 consecutive cycles, ack held high.
   - Required: wb_id sequence 0,1,2,3 on consecutive cycles, each result matching its launch.
4. Full simultaneous issue/ack:
   - Stimulus: occupancy=3, issue id=7 and ack in the same cycle.
   - Required: occupancy stays 3; id 7 queued at the tail; ready stays 1 when grid_ready=1.
5. Hold stability:
   - Stimulus: done=1, ack held low 5 cycles while a new grid_done arrives.
   - Required: wb_id/rd unchanged for all 5 cycles; second result presented the cycle after ack.
6. Reset mid-operation:
   - Stimulus: 2 ops outstanding, rst=0 for 1 cycle.
   - Required: done=0, locked=0, protocol_err=0, ready=grid_ready; a subsequent issue of id=5 completes normally.

Source files
------------

// File: rtl/rca_wb_sequencer_pkg.sv
// rca_wb_sequencer_pkg: shared sizes and types for the RCA writeback sequencer
package rca_wb_sequencer_pkg;
    localparam int XLEN            = 32;
    localparam int NUM_WRITE_PORTS = 5;
    localparam int MAX_IDS         = 8;
    localparam int RCA_WB_DEPTH    = 4;
    localparam int ID_W            = $clog2(MAX_IDS);

    typedef logic [ID_W-1:0] id_t;
    typedef logic [NUM_WRITE_PORTS-1:0][XLEN-1:0] rca_wb_result_t;
endpackage

// File: rtl/rca_wb_fifo.sv
// rca_wb_fifo: in-order synchronous FIFO; a pop frees a slot for a same-cycle push even when full
module rca_wb_fifo #(
    parameter int W = 8,
    parameter int D = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_push,
    input  logic               i_pop,
    input  logic [W-1:0]       i_din,
    output logic [W-1:0]       o_head,
    output logic [$clog2(D):0] o_count,
    output logic               o_full,
    output logic               o_empty
);
    localparam int AW = $clog2(D);

    logic [W-1:0]  r_mem [D];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_head  = r_mem[r_rd];
    assign o_count = r_count;
    assign o_full  = r_count == (AW+1)'(D);
    assign o_empty = r_count == '0;

    // pointers wrap naturally since D is a power of two
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    // storage needs no reset: contents are only visible through a non-empty head
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr] <= i_din;
    end
endmodule

// File: rtl/rca_wb_sequencer.sv
// rca_wb_sequencer: tags issued RCA ops, collects grid results in order and presents them for writeback
module rca_wb_sequencer
    import rca_wb_sequencer_pkg::*;
#(
    parameter int DEPTH = RCA_WB_DEPTH
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_new_request,
    input  id_t                             i_issue_id,
    output logic                            o_ready,
    output logic                            o_grid_start,
    input  logic                            i_grid_ready,
    input  logic                            i_grid_done,
    input  logic [NUM_WRITE_PORTS*XLEN-1:0] i_grid_results,
    output logic                            o_done,
    output id_t                             o_wb_id,
    output logic [NUM_WRITE_PORTS*XLEN-1:0] o_rd,
    input  logic                            i_ack,
    output logic                            o_rca_config_locked,
    output logic                            o_protocol_err
);
    localparam int CW = $clog2(DEPTH) + 1;

    id_t            w_id_head;
    rca_wb_result_t w_res_head;
    logic [CW-1:0]  w_id_cnt;
    logic [CW-1:0]  w_res_cnt;
    logic           w_id_full;
    logic           w_id_empty;
    logic           w_res_full;
    logic           w_res_empty;
    logic           w_issue;
    logic           w_res_push;
    logic           w_ack;
    logic           r_err;

    assign o_ready             = !w_id_full && i_grid_ready;
    assign w_issue             = i_rst && i_new_request && o_ready;
    assign o_grid_start        = w_issue;
    // a result is only legal while there are more launches than collected results
    assign w_res_push          = i_grid_done && !w_res_full && (w_res_cnt != w_id_cnt);
    assign o_done              = !w_res_empty;
    assign w_ack               = i_ack && o_done;
    assign o_wb_id             = o_done ? w_id_head : '0;
    assign o_rd                = o_done ? w_res_head : '0;
    assign o_rca_config_locked = !w_id_empty;
    assign o_protocol_err      = r_err;

    rca_wb_fifo #(.W(ID_W), .D(DEPTH)) u_id_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_issue),
        .i_pop   (w_ack),
        .i_din   (i_issue_id),
        .o_head  (w_id_head),
        .o_count (w_id_cnt),
        .o_full  (w_id_full),
        .o_empty (w_id_empty)
    );

    rca_wb_fifo #(.W($bits(rca_wb_result_t)), .D(DEPTH)) u_res_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_res_push),
        .i_pop   (w_ack),
        .i_din   (i_grid_results),
        .o_head  (w_res_head),
        .o_count (w_res_cnt),
        .o_full  (w_res_full),
        .o_empty (w_res_empty)
    );

    // sticky flag for over-issue, unexpected grid result, or ack with nothing presented
    always_ff @(posedge i_clk) begin
        if (!i_rst) r_err <= 1'b0;
        else if ((i_new_request && !o_ready) || (i_grid_done && !w_res_push) || (i_ack && !o_done)) r_err <= 1'b1;
    end
endmodule

// File: tb/tb_rca_wb_sequencer.sv
// tb_rca_wb_sequencer: table-driven cycle vectors plus a bounded-latency writeback sequence
module tb_rca_wb_sequencer;
    import rca_wb_sequencer_pkg::*;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           nr = 1'b0;
    id_t            iid = '0;
    logic           gr = 1'b1;
    logic           gd = 1'b0;
    rca_wb_result_t gres = '0;
    logic           ack = 1'b0;
    logic           ready, gs, done, locked, perr;
    id_t            wb;
    rca_wb_result_t rd;
    int             n_cmp = 0;
    int             n_bad = 0;

    rca_wb_sequencer dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_new_request       (nr),
        .i_issue_id          (iid),
        .o_ready             (ready),
        .o_grid_start        (gs),
        .i_grid_ready        (gr),
        .i_grid_done         (gd),
        .i_grid_results      (gres),
        .o_done              (done),
        .o_wb_id             (wb),
        .o_rd                (rd),
        .i_ack               (ack),
        .o_rca_config_locked (locked),
        .o_protocol_err      (perr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rst, nr; int id; logic gr, gd; int gb; logic ack;
        logic er, eg, ed; int ew; int erb; logic el, ee;
    } vec_t;

    vec_t q[$];

    function automatic rca_wb_result_t mk(input int b);
        rca_wb_result_t r;
        for (int k = 0; k < NUM_WRITE_PORTS; k++) r[k] = XLEN'(b + 'h11 * (k + 1));
        return r;
    endfunction

    function automatic vec_t v(input int a_rst, a_nr, a_id, a_gr, a_gd, a_gb, a_ack,
                               a_er, a_eg, a_ed, a_ew, a_erb, a_el, a_ee);
        vec_t t;
        t.rst = a_rst[0]; t.nr = a_nr[0]; t.id = a_id; t.gr = a_gr[0]; t.gd = a_gd[0];
        t.gb = a_gb; t.ack = a_ack[0]; t.er = a_er[0]; t.eg = a_eg[0]; t.ed = a_ed[0];
        t.ew = a_ew; t.erb = a_erb; t.el = a_el[0]; t.ee = a_ee[0];
        return t;
    endfunction

    task automatic chk(input string nm, input logic [$bits(rca_wb_result_t)-1:0] act,
                       input logic [$bits(rca_wb_result_t)-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    initial begin
        int c;
        //        rst nr id gr gd gb     ack  rdy gs dn wb rb     lk er
        q.push_back(v(0, 0, 0, 1, 0, 0,      0,   1, 0, 0, 0, 0,      0, 0));
        q.push_back(v(0, 0, 0, 0, 0, 0,      0,   0, 0, 0, 0, 0,      0, 0));
        q.push_back(v(1, 1, 3, 1, 0, 0,      0,   1, 1, 0, 0, 0,      0, 0));
        q.push_back(v(1, 0, 0, 1, 0, 0,      0,   1, 0, 0, 0, 0,      1, 0));
        q.push_back(v(1, 0, 0, 1, 1, 0,      0,   1, 0, 0, 0, 0,      1, 0));
        q.push_back(v(1, 0, 0, 1, 0, 0,      0,   1, 0, 1, 3, 0,      1, 0));
        q.push_back(v(1, 0, 0, 1, 0, 0,      1,   1, 0, 1, 3, 0,      1, 0));
        q.push_back(v(1, 0, 0, 1, 0, 0,      0,   1, 0, 0, 0, 0,      0, 0));
        q.push_back(v(1, 1, 0, 1, 0, 0,      0,   1, 1, 0, 0, 0,      0, 0));
        q.push_back(v(1, 1, 1, 1, 0, 0,      0,   1, 1, 0, 0, 0,      1, 0));
        q.push_back(v(1, 1, 2, 1, 0, 0,      0,   1, 1, 0, 0, 0,      1, 0));
        q.push_back(v(1, 1, 3, 1, 0, 0,      0,   1, 1, 0, 0, 0,      1, 0));
        q.push_back(v(1, 1, 4, 1, 0, 0,      0,   0, 0, 0, 0, 0,      1, 0));
        q.push_back(v(1, 0, 0, 1, 0, 0,      0,   0, 0, 0, 0, 0,      1, 1));
        q.push_back(v(1, 0, 0, 1, 1, 'h100,  1,   0, 0, 0, 0, 0,      1, 1));
        q.push_back(v(1, 0, 0, 1, 1, 'h200,  1,   0, 0, 1, 0, 'h100,  1, 1));
        q.push_back(v(1, 0, 0, 1, 1, 'h300,  1,   1, 0, 1, 1, 'h200,  1, 1));
        q.push_back(v(1, 0, 0, 1, 1, 'h400,  1,   1, 0, 1, 2, 'h300,  1, 1));
        q.push_back(v(1, 0, 0, 1, 0, 0,      1,   1, 0, 1, 3, 'h400,  1, 1));
        q.push_back(v(1, 0, 0, 1, 0, 0,      0,   1, 0, 0, 0, 0,      0, 1));
        q.push_back(v(1, 1, 4, 1, 0, 0,      0,   1, 1, 0, 0, 0,      0, 1));
        q.push_back(v(1, 1, 5, 1, 1, 'h500,  0,   1, 1, 0, 0, 0,      1, 1));
        q.push_back(v(1, 1, 6, 1, 0, 0,      0,   1, 1, 1, 4, 'h500,  1, 1));
        q.push_back(v(1, 1, 7, 1, 0, 0,      1,   1, 1, 1, 4, 'h500,  1, 1));
        q.push_back(v(1, 0, 0, 1, 1, 'h600,  0,   1, 0, 0, 0, 0,      1, 1));
        q.push_back(v(1, 0, 0, 1, 1, 'h700,  0,   1, 0, 1, 5, 'h600,  1, 1));
        for (int k = 0; k < 4; k++)
            q.push_back(v(1, 0, 0, 1, 0, 0,  0,   1, 0, 1, 5, 'h600,  1, 1));
        q.push_back(v(1, 0, 0, 1, 0, 0,      1,   1, 0, 1, 5, 'h600,  1, 1));
        q.push_back(v(1, 0, 0, 1, 0, 0,      0,   1, 0, 1, 6, 'h700,  1, 1));
        q.push_back(v(1, 0, 0, 1, 1, 'h800,  1,   1, 0, 1, 6, 'h700,  1, 1));
        q.push_back(v(1, 1, 1, 1, 0, 0,      0,   1, 1, 1, 7, 'h800,  1, 1));
        q.push_back(v(0, 0, 0, 1, 0, 0,      0,   1, 0, 1, 7, 'h800,  1, 1));
        q.push_back(v(1, 0, 0, 0, 0, 0,      0,   0, 0, 0, 0, 0,      0, 0));
        q.push_back(v(1, 0, 0, 1, 0, 0,      0,   1, 0, 0, 0, 0,      0, 0));
        q.push_back(v(1, 1, 5, 1, 0, 0,      0,   1, 1, 0, 0, 0,      0, 0));
        q.push_back(v(1, 0, 0, 1, 0, 0,      0,   1, 0, 0, 0, 0,      1, 0));
        q.push_back(v(1, 0, 0, 1, 1, 'h900,  0,   1, 0, 0, 0, 0,      1, 0));
        q.push_back(v(1, 0, 0, 1, 0, 0,      1,   1, 0, 1, 5, 'h900,  1, 0));
        q.push_back(v(1, 0, 0, 1, 0, 0,      0,   1, 0, 0, 0, 0,      0, 0));
        q.push_back(v(1, 0, 0, 1, 1, 'ha00,  0,   1, 0, 0, 0, 0,      0, 0));
        q.push_back(v(1, 0, 0, 1, 0, 0,      0,   1, 0, 0, 0, 0,      0, 1));

        repeat (2) @(posedge clk);
        #1;
        foreach (q[i]) begin
            rst = q[i].rst; nr = q[i].nr; iid = id_t'(q[i].id); gr = q[i].gr;
            gd = q[i].gd; gres = mk(q[i].gb); ack = q[i].ack;
            @(negedge clk);
            chk($sformatf("row%0d ctl{rdy,gs,done,wb,lk,err}", i), {ready, gs, done, wb, locked, perr},
                {q[i].er, q[i].eg, q[i].ed, id_t'(q[i].ew), q[i].el, q[i].ee});
            chk($sformatf("row%0d rd", i), rd, q[i].ed ? mk(q[i].erb) : '0);
            @(posedge clk);
            #1;
        end

        rst = 1'b0; nr = 1'b0; gd = 1'b0; ack = 1'b0; gr = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1; nr = 1'b1; iid = 2;
        @(posedge clk); #1;
        nr = 1'b0; gd = 1'b1; gres = mk('hb00);
        @(posedge clk); #1;
        gd = 1'b0;
        c = 0;
        while (!done && c < 10) begin
            @(posedge clk); #1;
            c++;
        end
        chk("seq done", done, 1'b1);
        chk("seq latency", c, 0);
        chk("seq wb_id", wb, 2);
        chk("seq rd", rd, mk('hb00));
        ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
        chk("seq done after ack", done, 1'b0);
        chk("seq locked after ack", locked, 1'b0);
        chk("seq err", perr, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
